axis_frame_checker: RTL and testbench

AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

---
 rtl/axis_chk_pkg.sv | 22 ++
 rtl/axis_ready_prbs.sv | 15 +
 rtl/axis_frame_checker.sv | 162 ++++++++++++++++
 tb/tb_axis_frame_checker.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types, widths and helpers for the AXI-Stream frame checker.
package axis_chk_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RM_ALWAYS      = 2'd0,
    RM_RANDOM      = 2'd1,
    RM_AFTER_VALID = 2'd2,
    RM_HOLD        = 2'd3
  } ready_mode_e;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } chk_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_ready_prbs.sv
// 33-bit free-running PRBS used to randomise tready backpressure.
module axis_ready_prbs #(
  parameter logic [32:0] SEED = 33'd1246504138
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [32:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= {state[31:0], state[32] ^ ~state[19]};
  end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream video frame checker: tracks SOF/EOL framing, counts errors and
// timeouts, and generates configurable tready backpressure.
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int          X_SIZE   = 192,
  parameter int          Y_SIZE   = 256,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 1000000,
  parameter logic [32:0] RND_SEED = 33'd1246504138
) (
  input  logic              out_stream_aclk,
  input  logic              axi_resetn,
  input  logic [DATA_W-1:0] in_stream_tdata,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tlast,
  input  logic [1:0]        ready_mode,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  sof_err_count,
  output logic [CNT_W-1:0]  eol_err_count,
  output logic [CNT_W-1:0]  timeout_count,
  output logic              frame_ok,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  x_pos,
  output logic [CNT_W-1:0]  y_pos,
  output chk_state_e        fsm_state
);

  localparam logic [CNT_W-1:0] LAST_X   = CNT_W'(X_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_Y   = CNT_W'(Y_SIZE - 1);
  localparam logic [31:0]      IDLE_MAX = 32'(TIMEOUT - 1);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] x_q, y_q, x_d, y_d, x_cur, y_cur;
  logic             ferr_q, ferr_d;
  logic             beat, in_line, sof_err, eol_err, frame_start, frame_done;
  logic             tmo_hit, tready_d;
  logic [31:0]      idle_q;
  logic [32:0]      prbs;
  logic             unused_bits;

  // Handshake: a beat is tvalid & tready at a rising edge; tready is a
  // registered output, so the source sees backpressure one cycle ahead.
  assign beat        = in_stream_tvalid & in_stream_tready;
  assign tmo_hit     = !in_stream_tvalid && (idle_q == IDLE_MAX);
  assign unused_bits = ^{in_stream_tdata, prbs[31:0]};

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign fsm_state = state_q;

  axis_ready_prbs #(.SEED(RND_SEED)) u_prbs (
    .clk   (out_stream_aclk),
    .rst_n (axi_resetn),
    .state (prbs)
  );

  always_comb begin
    tready_d = 1'b0;
    case (ready_mode_e'(ready_mode))
      RM_ALWAYS:      tready_d = 1'b1;
      RM_RANDOM:      tready_d = prbs[32];
      RM_AFTER_VALID: tready_d = in_stream_tvalid & ~in_stream_tready;
      default:        tready_d = 1'b0;
    endcase
  end

  // SOF handling first, then EOL evaluation on the (possibly restarted) position.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    ferr_d      = ferr_q;
    x_cur       = x_q;
    y_cur       = y_q;
    in_line     = 1'b0;
    sof_err     = 1'b0;
    eol_err     = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    if (beat) begin
      if (in_stream_tuser) begin
        frame_start = 1'b1;
        sof_err     = (state_q == IN_FRAME) && ((x_q != '0) || (y_q != '0));
        x_cur       = '0;
        y_cur       = '0;
        ferr_d      = 1'b0;
        in_line     = 1'b1;
        state_d     = IN_FRAME;
      end else if (state_q == IN_FRAME) begin
        in_line = 1'b1;
      end else begin
        sof_err = 1'b1;
      end
      if (in_line) begin
        if (in_stream_tlast) begin
          eol_err = (x_cur < LAST_X);
          x_d     = '0;
          if (y_cur == LAST_Y) begin
            y_d        = '0;
            state_d    = WAIT_SOF;
            frame_done = 1'b1;
          end else begin
            y_d = sat_inc(y_cur);
          end
        end else begin
          eol_err = (x_cur == LAST_X);
          x_d     = sat_inc(x_cur);
          y_d     = y_cur;
        end
        if (eol_err) ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q          <= WAIT_SOF;
      x_q              <= '0;
      y_q              <= '0;
      ferr_q           <= 1'b0;
      frame_ok         <= 1'b0;
      in_stream_tready <= 1'b0;
      idle_q           <= '0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      ferr_q           <= ferr_d;
      frame_ok         <= frame_done & ~ferr_d;
      in_stream_tready <= tready_d;
      if (in_stream_tvalid || tmo_hit) idle_q <= '0;
      else                             idle_q <= idle_q + 32'd1;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      frame_count   <= '0;
      sof_err_count <= '0;
      eol_err_count <= '0;
      timeout_count <= '0;
      err_sticky    <= 1'b0;
    end else if (clr_counts) begin
      frame_count   <= '0;
      sof_err_count <= '0;
      eol_err_count <= '0;
      timeout_count <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (frame_start) frame_count   <= sat_inc(frame_count);
      if (sof_err)     sof_err_count <= sat_inc(sof_err_count);
      if (eol_err)     eol_err_count <= sat_inc(eol_err_count);
      if (tmo_hit)     timeout_count <= sat_inc(timeout_count);
      if (sof_err || eol_err || tmo_hit) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: directed framing scenarios plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_axis_frame_checker;
  import axis_chk_pkg::*;

  localparam int          X_SIZE      = 4;
  localparam int          Y_SIZE      = 3;
  localparam int          DATA_W      = 32;
  localparam int          TIMEOUT     = 10;
  localparam logic [32:0] SEED        = 33'd1246504138;
  localparam int          BEAT_BUDGET = 200;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] tdata;
  logic              tvalid, tready, tuser, tlast, clr;
  logic [1:0]        mode;
  logic [15:0]       frame_count, sof_err_count, eol_err_count, timeout_count;
  logic              frame_ok, err_sticky;
  logic [15:0]       x_pos, y_pos;
  chk_state_e        fsm_state;

  axis_frame_checker #(
    .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .RND_SEED(SEED)
  ) dut (
    .out_stream_aclk  (clk),
    .axi_resetn       (rst_n),
    .in_stream_tdata  (tdata),
    .in_stream_tvalid (tvalid),
    .in_stream_tready (tready),
    .in_stream_tuser  (tuser),
    .in_stream_tlast  (tlast),
    .ready_mode       (mode),
    .clr_counts       (clr),
    .frame_count      (frame_count),
    .sof_err_count    (sof_err_count),
    .eol_err_count    (eol_err_count),
    .timeout_count    (timeout_count),
    .frame_ok         (frame_ok),
    .err_sticky       (err_sticky),
    .x_pos            (x_pos),
    .y_pos            (y_pos),
    .fsm_state        (fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ok_seen  = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // ---------------- behavioural model ----------------
  bit        m_tready, m_nt, m_infr, m_ferr, m_ok, m_sticky;
  bit        m_beat, m_start, m_done, e_sof, e_eol, e_tmo;
  bit [32:0] m_prbs;
  int        m_x, m_y, m_frames, m_sof, m_eol, m_tmo, m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tready = 0; m_prbs = SEED; m_infr = 0; m_x = 0; m_y = 0; m_ferr = 0;
      m_ok = 0; m_frames = 0; m_sof = 0; m_eol = 0; m_tmo = 0; m_sticky = 0;
      m_idle = 0;
      exp_q.delete();
    end else begin
      m_beat = tvalid && m_tready;
      case (mode)
        2'd0:    m_nt = 1'b1;
        2'd1:    m_nt = m_prbs[32];
        2'd2:    m_nt = tvalid && !m_tready;
        default: m_nt = 1'b0;
      endcase
      m_tready = m_nt;
      m_prbs   = {m_prbs[31:0], m_prbs[32] ^ ~m_prbs[19]};
      e_sof = 0; e_eol = 0; e_tmo = 0; m_start = 0; m_done = 0;
      if (m_beat) begin
        if (tuser) begin
          m_start = 1;
          e_sof   = m_infr && (m_x != 0 || m_y != 0);
          m_infr  = 1; m_x = 0; m_y = 0; m_ferr = 0;
        end else if (!m_infr) begin
          e_sof = 1;
        end
        if (m_infr) begin
          if (tlast) begin
            e_eol = (m_x < X_SIZE - 1);
            m_x   = 0;
            if (m_y == Y_SIZE - 1) begin m_y = 0; m_infr = 0; m_done = 1; end
            else m_y = m_y + 1;
          end else begin
            e_eol = (m_x == X_SIZE - 1);
            m_x   = sat16(m_x + 1);
          end
          if (e_eol) m_ferr = 1;
        end
      end
      if (tvalid) m_idle = 0;
      else begin
        m_idle = m_idle + 1;
        if (m_idle == TIMEOUT) begin e_tmo = 1; m_idle = 0; end
      end
      m_ok = m_done && !m_ferr;
      if (clr) begin
        m_frames = 0; m_sof = 0; m_eol = 0; m_tmo = 0; m_sticky = 0;
      end else begin
        if (m_start) m_frames = sat16(m_frames + 1);
        if (e_sof)   m_sof    = sat16(m_sof + 1);
        if (e_eol)   m_eol    = sat16(m_eol + 1);
        if (e_tmo)   m_tmo    = sat16(m_tmo + 1);
        if (e_sof || e_eol || e_tmo) m_sticky = 1;
      end
      if (m_ok) exp_q.push_back(16'(m_frames));
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    chk("tready",      32'(tready),        32'(m_tready));
    chk("frame_count", 32'(frame_count),   m_frames);
    chk("sof_err",     32'(sof_err_count), m_sof);
    chk("eol_err",     32'(eol_err_count), m_eol);
    chk("timeouts",    32'(timeout_count), m_tmo);
    chk("frame_ok",    32'(frame_ok),      32'(m_ok));
    chk("err_sticky",  32'(err_sticky),    32'(m_sticky));
    chk("x_pos",       32'(x_pos),         m_x);
    chk("y_pos",       32'(y_pos),         m_y);
    chk("state",       32'(fsm_state),     32'(m_infr));
    if (frame_ok) begin
      ok_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL ok_unexpected: frame_ok with no expected frame at %0t", $time);
      end else begin
        chk("ok_frame_no", 32'(frame_count), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    tvalid = 0; tuser = 0; tlast = 0; clr = 0;
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic idle(input int n);
    tvalid = 0; tuser = 0; tlast = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit u, input bit l);
    int waited = 0;
    bit rdy;
    tvalid = 1; tuser = u; tlast = l; tdata = $urandom;
    do begin
      @(negedge clk); rdy = tready;
      @(posedge clk); #1;
      waited++;
    end while (!rdy && waited < BEAT_BUDGET);
    if (!rdy) begin
      n_checks++;
      $display("FAIL beat_wait: no tready after %0d cycles, required a beat", waited);
    end
  endtask

  task automatic send_line(input bit first);
    for (int x = 0; x < X_SIZE; x++) send_beat(first && x == 0, x == X_SIZE - 1);
  endtask

  task automatic send_frame(input int err_rate);
    for (int y = 0; y < Y_SIZE; y++) begin
      for (int x = 0; x < X_SIZE; x++) begin
        bit u, l;
        u = (x == 0 && y == 0);
        l = (x == X_SIZE - 1);
        if (err_rate > 0 && $urandom_range(0, err_rate - 1) == 0) u = ~u;
        if (err_rate > 0 && $urandom_range(0, err_rate - 1) == 0) l = ~l;
        send_beat(u, l);
        if (err_rate > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ok0;
    bit [7:0] prbs_exp;
    tdata = '0; tvalid = 0; tuser = 0; tlast = 0; clr = 0; mode = 2'd0;

    // Two clean frames back to back
    do_reset();
    ok0 = ok_seen;
    send_frame(0);
    send_frame(0);
    idle(2);
    chk("a_frame_count", 32'(frame_count), 2);
    chk("a_sof_err", 32'(sof_err_count), 0);
    chk("a_eol_err", 32'(eol_err_count), 0);
    chk("a_timeouts", 32'(timeout_count), 0);
    chk("a_ok_pulses", ok_seen - ok0, 2);
    chk("a_model_frames", m_frames, 2);

    // Missing tlast on last word, tlast one word late
    do_reset();
    ok0 = ok_seen;
    send_beat(1, 0); send_beat(0, 0); send_beat(0, 0); send_beat(0, 0); send_beat(0, 1);
    chk("b_eol_err", 32'(eol_err_count), 1);
    chk("b_y_pos", 32'(y_pos), 1);
    chk("b_x_pos", 32'(x_pos), 0);
    send_line(0);
    send_line(0);
    idle(2);
    chk("b_ok_pulses", ok_seen - ok0, 0);
    chk("b_frame_count", 32'(frame_count), 1);
    chk("b_state", 32'(fsm_state), 32'(WAIT_SOF));

    // Early SOF at (2,1) restarts the frame
    do_reset();
    ok0 = ok_seen;
    send_line(1);
    send_beat(0, 0); send_beat(0, 0);
    send_beat(1, 0);
    chk("c_sof_err", 32'(sof_err_count), 1);
    chk("c_frame_count", 32'(frame_count), 2);
    chk("c_x_pos", 32'(x_pos), 1);
    chk("c_y_pos", 32'(y_pos), 0);
    send_beat(0, 0); send_beat(0, 0); send_beat(0, 1);
    send_line(0);
    send_line(0);
    idle(2);
    chk("c_ok_pulses", ok_seen - ok0, 1);
    chk("c_eol_err", 32'(eol_err_count), 0);

    // Reset mid-frame, then a beat without SOF
    do_reset();
    send_beat(1, 0); send_beat(0, 0);
    do_reset();
    chk("d_rst_frames", 32'(frame_count), 0);
    chk("d_rst_x", 32'(x_pos), 0);
    chk("d_rst_sticky", 32'(err_sticky), 0);
    send_beat(0, 0);
    chk("d_sof_err", 32'(sof_err_count), 1);
    chk("d_state", 32'(fsm_state), 32'(WAIT_SOF));
    chk("d_x_pos", 32'(x_pos), 0);
    idle(1);

    // Idle timeout and counter clear
    do_reset();
    repeat (25) @(posedge clk);
    #1;
    chk("e_timeouts", 32'(timeout_count), 2);
    chk("e_sticky", 32'(err_sticky), 1);
    clr = 1;
    @(posedge clk); #1 clr = 0;
    chk("e_clr_timeouts", 32'(timeout_count), 0);
    chk("e_clr_sticky", 32'(err_sticky), 0);

    // First tready values in RANDOM mode follow the seed's top bits
    mode = 2'd1;
    do_reset();
    prbs_exp = 8'b0010_0101;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("f_prbs_tready", 32'(tready), 32'(prbs_exp[7 - i]));
      chk("f_prbs_model", 32'(m_tready), 32'(prbs_exp[7 - i]));
    end

    // Randomized framed traffic under random / after-valid backpressure
    ok0 = ok_seen;
    send_frame(0);
    repeat (40) begin
      mode = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd1;
      send_frame(($urandom_range(0, 1) == 0) ? 0 : 10);
    end
    chk("g_some_ok", 32'(ok_seen - ok0 > 0), 1);
    idle(3);

    // Free-running random inputs including mode changes and clears
    repeat (400) begin
      @(posedge clk); #1;
      tvalid = 1'($urandom_range(0, 1));
      tuser  = ($urandom_range(0, 7) == 0);
      tlast  = ($urandom_range(0, 3) == 0);
      mode   = 2'($urandom_range(0, 3));
      clr    = ($urandom_range(0, 40) == 0);
    end
    clr = 0;
    idle(3);

    chk("ok_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
